// File: rtl/pocket_audio_pkg.sv
// Shared audio-path types and constants for the Pocket I2S blocks.
package pocket_audio_pkg;

   localparam int unsigned AUDIO_W    = 16;
   localparam int unsigned I2S_SLOT_W = 32;

   typedef logic [AUDIO_W-1:0] audio_sample_t;

   typedef enum logic {
      HUNT,
      RUN
   } rx_state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-stage synchronizer for a serial clock plus WIDTH level signals.
// The clock input also gets a history flop and a rising-edge strobe; the
// level inputs only pass through the synchronizer chain so they stay aligned
// with the clock. Reset is synchronous, active-low.
module i2s_sync_edge #(
   parameter int unsigned STAGES = 2,
   parameter int unsigned WIDTH  = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             edge_i,
   input  logic [WIDTH-1:0] lvl_i,
   output logic             rise_o,
   output logic [WIDTH-1:0] lvl_o
);

   logic [STAGES-1:0]            edge_sync_q, edge_sync_d;
   logic                         edge_hist_q, edge_hist_d;
   logic [STAGES-1:0][WIDTH-1:0] lvl_sync_q, lvl_sync_d;

   // Shift each input one stage deeper; history tracks the last synced clock
   always_comb begin
      edge_sync_d = {edge_sync_q[STAGES-2:0], edge_i};
      edge_hist_d = edge_sync_q[STAGES-1];
      lvl_sync_d  = {lvl_sync_q[STAGES-2:0], lvl_i};
   end

   // Synchronizer and history registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         edge_sync_q <= '0;
         edge_hist_q <= 1'b0;
         lvl_sync_q  <= '0;
      end else begin
         edge_sync_q <= edge_sync_d;
         edge_hist_q <= edge_hist_d;
         lvl_sync_q  <= lvl_sync_d;
      end
   end

   // Rising edge of the synchronized clock, and the synchronized levels
   always_comb begin
      rise_o = edge_sync_q[STAGES-1] & ~edge_hist_q;
      lvl_o  = lvl_sync_q[STAGES-1];
   end

endmodule

// File: rtl/pocket_i2s_rx.sv
// I2S receiver: oversamples SCLK/LRCK/DATA in the clk_74a domain, recovers
// left/right sample pairs and emits them with a single-cycle valid strobe.
// Reset is synchronous, active-low.
module pocket_i2s_rx
   import pocket_audio_pkg::*;
#(
   parameter int unsigned DATA_W          = AUDIO_W,
   parameter int unsigned SLOT_W          = I2S_SLOT_W,
   parameter int unsigned LEFT_LRCK_LEVEL = 1,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned TIMEOUT         = 1023
) (
   input  logic              clk_74a,
   input  logic              reset_n,
   input  logic              i2s_sclk,
   input  logic              i2s_lrck,
   input  logic              i2s_data,
   output logic [DATA_W-1:0] audio_l,
   output logic [DATA_W-1:0] audio_r,
   output logic              sample_valid,
   output logic              frame_err,
   output logic              locked
);

   localparam int unsigned CNT_W = $clog2(SLOT_W + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] DataCnt = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] LastBit = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] SlotCnt = CNT_W'(SLOT_W);
   localparam logic [TMO_W-1:0] TmoMax  = TMO_W'(TIMEOUT);
   localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TIMEOUT - 1);
   localparam logic             LeftLvl = (LEFT_LRCK_LEVEL != 0);

   logic       sclk_rise;
   logic [1:0] lvl_s;
   logic       lrck_s, data_s;

   rx_state_e state_q, state_d;

   logic              lrck_prev_q, lrck_prev_d;
   logic              prev_valid_q, prev_valid_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] left_hold_q, left_hold_d;
   logic              left_valid_q, left_valid_d;
   logic              right_done_q, right_done_d;
   logic [1:0]        good_frames_q, good_frames_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [DATA_W-1:0] audio_l_q, audio_l_d;
   logic [DATA_W-1:0] audio_r_q, audio_r_d;
   logic              sample_valid_q, sample_valid_d;
   logic              frame_err_q, frame_err_d;

   logic lrck_edge;
   logic word_done;
   logic timeout_evt;
   logic capture_en;

   i2s_sync_edge #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (2)
   ) u_sync (
      .clk_i  (clk_74a),
      .rst_ni (reset_n),
      .edge_i (i2s_sclk),
      .lvl_i  ({i2s_lrck, i2s_data}),
      .rise_o (sclk_rise),
      .lvl_o  (lvl_s)
   );

   // Event decode on the synchronized stream
   always_comb begin
      lrck_s      = lvl_s[1];
      data_s      = lvl_s[0];
      // The first rise after reset only seeds lrck_prev; it is not a transition
      lrck_edge   = sclk_rise && prev_valid_q && (lrck_s != lrck_prev_q);
      word_done   = sclk_rise && !lrck_edge && (bit_cnt_q == LastBit);
      // A rise in the same cycle wins over the timeout
      timeout_evt = !sclk_rise && (tmo_q == TmoLast);
   end

   // FSM state register
   always_ff @(posedge clk_74a) begin
      if (!reset_n) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: hunt for the first LRCK transition, drop back on timeout
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         HUNT:    if (lrck_edge)   state_d = RUN;
         RUN:     if (timeout_evt) state_d = HUNT;
         default: state_d = HUNT;
      endcase
   end

   // FSM outputs
   always_comb begin
      capture_en = (state_q == RUN);
      locked     = capture_en && (good_frames_q == 2'd2);
   end

   // Datapath next state: bit counting, shifting, word hand-off and timeout
   always_comb begin
      lrck_prev_d    = lrck_prev_q;
      prev_valid_d   = prev_valid_q;
      bit_cnt_d      = bit_cnt_q;
      shreg_d        = shreg_q;
      left_hold_d    = left_hold_q;
      left_valid_d   = left_valid_q;
      right_done_d   = 1'b0;
      good_frames_d  = good_frames_q;
      tmo_d          = tmo_q;
      audio_l_d      = audio_l_q;
      audio_r_d      = audio_r_q;
      sample_valid_d = 1'b0;
      frame_err_d    = 1'b0;

      if (sclk_rise) begin
         tmo_d = '0;
      end else if (tmo_q != TmoMax) begin
         tmo_d = tmo_q + TMO_W'(1);
      end

      if (sclk_rise) begin
         lrck_prev_d  = lrck_s;
         prev_valid_d = 1'b1;
         // The rise that carries an LRCK change is the I2S delay slot
         if (lrck_edge) begin
            bit_cnt_d = '0;
         end else if (bit_cnt_q != SlotCnt) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
         end
         if (!lrck_edge && (bit_cnt_q < DataCnt)) begin
            shreg_d = {shreg_q[DATA_W-2:0], data_s};
         end
      end

      if (capture_en) begin
         if (lrck_edge && (bit_cnt_q != '0) && (bit_cnt_q < DataCnt)) begin
            frame_err_d   = 1'b1;
            left_valid_d  = 1'b0;
            good_frames_d = 2'd0;
         end
         if (word_done) begin
            if (lrck_s == LeftLvl) begin
               left_hold_d  = {shreg_q[DATA_W-2:0], data_s};
               left_valid_d = 1'b1;
            end else begin
               // Right word without a left word in this frame is dropped
               right_done_d = left_valid_q;
               left_valid_d = 1'b0;
            end
         end
      end

      // shreg still holds the right word: the next rise is several cycles away
      if (right_done_q) begin
         audio_l_d      = left_hold_q;
         audio_r_d      = shreg_q;
         sample_valid_d = 1'b1;
         if (good_frames_q != 2'd2) begin
            good_frames_d = good_frames_q + 2'd1;
         end
      end

      if (timeout_evt) begin
         left_valid_d  = 1'b0;
         good_frames_d = 2'd0;
      end
   end

   // Datapath registers
   always_ff @(posedge clk_74a) begin
      if (!reset_n) begin
         lrck_prev_q    <= 1'b0;
         prev_valid_q   <= 1'b0;
         bit_cnt_q      <= '0;
         shreg_q        <= '0;
         left_hold_q    <= '0;
         left_valid_q   <= 1'b0;
         right_done_q   <= 1'b0;
         good_frames_q  <= 2'd0;
         tmo_q          <= '0;
         audio_l_q      <= '0;
         audio_r_q      <= '0;
         sample_valid_q <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         lrck_prev_q    <= lrck_prev_d;
         prev_valid_q   <= prev_valid_d;
         bit_cnt_q      <= bit_cnt_d;
         shreg_q        <= shreg_d;
         left_hold_q    <= left_hold_d;
         left_valid_q   <= left_valid_d;
         right_done_q   <= right_done_d;
         good_frames_q  <= good_frames_d;
         tmo_q          <= tmo_d;
         audio_l_q      <= audio_l_d;
         audio_r_q      <= audio_r_d;
         sample_valid_q <= sample_valid_d;
         frame_err_q    <= frame_err_d;
      end
   end

   // Registered outputs
   always_comb begin
      audio_l      = audio_l_q;
      audio_r      = audio_r_q;
      sample_valid = sample_valid_q;
      frame_err    = frame_err_q;
   end

endmodule

// File: tb/tb_pocket_i2s_rx.sv
// Directed bench for pocket_i2s_rx: serializer-style I2S stream, SCLK = clk/24.
module tb_pocket_i2s_rx;
   import pocket_audio_pkg::*;

   logic          clk_74a;
   logic          reset_n;
   logic          i2s_sclk;
   logic          i2s_lrck;
   logic          i2s_data;
   audio_sample_t audio_l;
   audio_sample_t audio_r;
   logic          sample_valid;
   logic          frame_err;
   logic          locked;

   int n_cmp = 0;
   int n_err = 0;

   int            valid_cnt = 0;
   int            ferr_cnt  = 0;
   audio_sample_t last_l    = '0;
   audio_sample_t last_r    = '0;
   int            v0;
   int            f0;

   pocket_i2s_rx u_dut (
      .clk_74a      (clk_74a),
      .reset_n      (reset_n),
      .i2s_sclk     (i2s_sclk),
      .i2s_lrck     (i2s_lrck),
      .i2s_data     (i2s_data),
      .audio_l      (audio_l),
      .audio_r      (audio_r),
      .sample_valid (sample_valid),
      .frame_err    (frame_err),
      .locked       (locked)
   );

   initial clk_74a = 1'b0;
   always #5 clk_74a = ~clk_74a;

   // Pulse monitor: counts strobes and latches the words seen with each valid
   always @(negedge clk_74a) begin
      if (sample_valid === 1'b1) begin
         valid_cnt <= valid_cnt + 1;
         last_l    <= audio_l;
         last_r    <= audio_r;
      end
      if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One SCLK period: LRCK/DATA change with the falling edge, rise mid-period
   task automatic sclk_period(input logic lr, input logic d);
      @(negedge clk_74a);
      i2s_sclk = 1'b0;
      i2s_lrck = lr;
      i2s_data = d;
      repeat (11) @(negedge clk_74a);
      i2s_sclk = 1'b1;
      repeat (12) @(negedge clk_74a);
   endtask

   // nrises periods at one LRCK level: delay slot, 16 data bits MSB first, padding
   task automatic send_slot(input logic lr, input logic [15:0] w, input logic pad,
                            input int nrises);
      for (int i = 0; i < nrises; i++) begin
         if (i == 0 || i > 16) sclk_period(lr, pad);
         else sclk_period(lr, w[16-i]);
      end
   endtask

   task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input logic pad);
      send_slot(1'b1, l, pad, 32);
      send_slot(1'b0, r, pad, 32);
   endtask

   initial begin
      reset_n  = 1'b0;
      i2s_sclk = 1'b0;
      i2s_lrck = 1'b0;
      i2s_data = 1'b0;
      repeat (3) @(negedge clk_74a);
      check("rst_audio_l", 32'(audio_l), 32'h0);
      check("rst_audio_r", 32'(audio_r), 32'h0);
      check("rst_valid", 32'(sample_valid), 32'h0);
      check("rst_ferr", 32'(frame_err), 32'h0);
      check("rst_locked", 32'(locked), 32'h0);
      reset_n = 1'b1;

      // Nominal: short right-slot lead-in so the first left slot is a transition
      send_slot(1'b0, 16'h0000, 1'b0, 4);
      send_frame(16'hA55A, 16'h1234, 1'b0);
      check("nom1_cnt", 32'(valid_cnt), 32'd1);
      check("nom1_l", 32'(last_l), 32'hA55A);
      check("nom1_r", 32'(last_r), 32'h1234);
      check("nom1_locked", 32'(locked), 32'h0);
      send_frame(16'hA55A, 16'h1234, 1'b0);
      check("nom2_cnt", 32'(valid_cnt), 32'd2);
      check("nom2_locked", 32'(locked), 32'h1);
      send_frame(16'hA55A, 16'h1234, 1'b0);
      check("nom3_cnt", 32'(valid_cnt), 32'd3);
      check("nom3_l", 32'(last_l), 32'hA55A);
      check("nom3_r", 32'(last_r), 32'h1234);
      check("nom_out_l", 32'(audio_l), 32'hA55A);
      check("nom_ferr", 32'(ferr_cnt), 32'd0);

      // Reset halfway through a left word
      v0 = valid_cnt;
      send_slot(1'b1, 16'h7FFF, 1'b0, 12);
      @(negedge clk_74a);
      reset_n = 1'b0;
      repeat (2) @(negedge clk_74a);
      check("mid_rst_l", 32'(audio_l), 32'h0);
      check("mid_rst_r", 32'(audio_r), 32'h0);
      check("mid_rst_locked", 32'(locked), 32'h0);
      check("mid_rst_valid", 32'(sample_valid), 32'h0);
      reset_n = 1'b1;
      send_slot(1'b1, 16'h7FFF, 1'b0, 20);
      send_slot(1'b0, 16'h8000, 1'b0, 32);
      check("mid_rst_nopair", 32'(valid_cnt - v0), 32'd0);
      send_frame(16'h7FFF, 16'h8000, 1'b0);
      check("mid_rst_pair", 32'(valid_cnt - v0), 32'd1);
      check("mid_rst_pl", 32'(last_l), 32'h7FFF);
      check("mid_rst_pr", 32'(last_r), 32'h8000);
      send_frame(16'h7FFF, 16'h8000, 1'b0);
      check("relock", 32'(locked), 32'h1);

      // Short right word: LRCK toggles after 9 data bits
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_slot(1'b1, 16'h1111, 1'b0, 32);
      send_slot(1'b0, 16'h2222, 1'b0, 10);
      send_frame(16'h3333, 16'h4444, 1'b0);
      check("short_ferr", 32'(ferr_cnt - f0), 32'd1);
      check("short_valid", 32'(valid_cnt - v0), 32'd1);
      check("short_l", 32'(last_l), 32'h3333);
      check("short_r", 32'(last_r), 32'h4444);
      check("short_locked", 32'(locked), 32'h0);
      send_frame(16'h5555, 16'h6666, 1'b0);
      check("short_relock", 32'(locked), 32'h1);
      check("short_ferr_once", 32'(ferr_cnt - f0), 32'd1);

      // Clock stop: SCLK held high for 1100 cycles
      repeat (1000) @(negedge clk_74a);
      check("stop_before_tmo", 32'(locked), 32'h1);
      repeat (100) @(negedge clk_74a);
      check("stop_locked", 32'(locked), 32'h0);
      check("stop_hold_l", 32'(audio_l), 32'h5555);
      check("stop_hold_r", 32'(audio_r), 32'h6666);
      v0 = valid_cnt;
      send_frame(16'h0F0F, 16'hF0F0, 1'b0);
      check("resume_valid", 32'(valid_cnt - v0), 32'd1);
      check("resume_l", 32'(last_l), 32'h0F0F);
      check("resume_r", 32'(last_r), 32'hF0F0);

      // Extremes with padding and delay-slot bits forced high
      send_frame(16'hFFFF, 16'h0001, 1'b1);
      check("pad_l", 32'(last_l), 32'hFFFF);
      check("pad_r", 32'(last_r), 32'h0001);
      send_frame(16'h0000, 16'h0000, 1'b1);
      check("pad_zero_l", 32'(last_l), 32'h0000);
      check("pad_zero_r", 32'(last_r), 32'h0000);

      // Start phase: stream begins mid-right-word after reset
      @(negedge clk_74a);
      reset_n = 1'b0;
      repeat (2) @(negedge clk_74a);
      reset_n = 1'b1;
      v0 = valid_cnt;
      send_slot(1'b0, 16'h9999, 1'b0, 20);
      check("phase_none", 32'(valid_cnt - v0), 32'd0);
      send_frame(16'h1357, 16'h2468, 1'b0);
      check("phase_valid", 32'(valid_cnt - v0), 32'd1);
      check("phase_l", 32'(last_l), 32'h1357);
      check("phase_r", 32'(last_r), 32'h2468);
      check("final_ferr", 32'(ferr_cnt - f0), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
